// File: rtl/enc_slice_seq.sv
// Slice sequencer: captures one full hypervector bundle and streams it
// out DIMS_PER_CC dimensions per handshake, zero-padding the tail slice.
module enc_slice_seq #(
    parameter int FEATURE_COUNT = 8,
    parameter int HV_DIM        = 5000,
    parameter int DIMS_PER_CC   = 500,
    localparam int NUM_SLICES   = (HV_DIM + DIMS_PER_CC - 1) / DIMS_PER_CC,
    localparam int IDX_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FEATURE_COUNT-1:0] bits_to_bundle_arr [HV_DIM],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FEATURE_COUNT-1:0] out_slice [DIMS_PER_CC],
    output logic [DIMS_PER_CC-1:0]   out_lane_valid,
    output logic [IDX_W-1:0]         slice_idx,
    output logic                     out_last
);

    localparam int DW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                   state;
    state_t                   state_d;
    logic [IDX_W-1:0]         idx_d;
    logic                     cap;
    logic                     last;
    logic [FEATURE_COUNT-1:0] vec [HV_DIM];

    assign last      = (slice_idx == LAST_IDX);
    assign in_ready  = (state == IDLE) && !clear;
    assign out_valid = (state == STREAM);
    assign out_last  = (state == STREAM) && last;

    always_comb begin
        state_d = state;
        idx_d   = slice_idx;
        cap     = 1'b0;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap     = 1'b1;
                        state_d = STREAM;
                        idx_d   = '0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (last) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = slice_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slice_idx <= '0;
        end else begin
            state     <= state_d;
            slice_idx <= idx_d;
        end
    end

    // Payload is qualified by state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            vec <= bits_to_bundle_arr;
        end
    end

    for (genvar j = 0; j < DIMS_PER_CC; j++) begin : g_lane
        logic [31:0] d;
        assign d = 32'(slice_idx) * 32'(DIMS_PER_CC) + 32'(j);
        assign out_lane_valid[j] = (d < 32'(HV_DIM));
        assign out_slice[j] = out_lane_valid[j] ? vec[d[DW-1:0]] : '0;
    end

endmodule

// File: tb/tb_enc_slice_seq.sv
// Directed bench: 3-slice instance with padded tail plus a single-slice
// instance; covers capture, backpressure, clear and async reset.
module tb_enc_slice_seq;

    localparam int FC  = 8;
    localparam int AHV = 1100;
    localparam int ADC = 500;
    localparam int BHV = 4;
    localparam int BDC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic out_ready = 1'b0;

    logic          a_in_valid = 1'b0;
    logic          a_in_ready;
    logic [FC-1:0] a_vec [AHV];
    logic          a_out_valid;
    logic [FC-1:0] a_slice [ADC];
    logic [ADC-1:0] a_lv;
    logic [1:0]    a_idx;
    logic          a_last;

    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [FC-1:0] b_vec [BHV];
    logic          b_out_valid;
    logic [FC-1:0] b_slice [BDC];
    logic [BDC-1:0] b_lv;
    logic [0:0]    b_idx;
    logic          b_last;

    int total = 0;
    int bad = 0;

    enc_slice_seq #(.FEATURE_COUNT(FC), .HV_DIM(AHV), .DIMS_PER_CC(ADC)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .bits_to_bundle_arr(a_vec),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_slice(a_slice), .out_lane_valid(a_lv),
        .slice_idx(a_idx), .out_last(a_last)
    );

    enc_slice_seq #(.FEATURE_COUNT(FC), .HV_DIM(BHV), .DIMS_PER_CC(BDC)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .bits_to_bundle_arr(b_vec),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_slice(b_slice), .out_lane_valid(b_lv),
        .slice_idx(b_idx), .out_last(b_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mv(int d, int off);
        return 8'((d + off) % 256);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a(int off);
        for (int d = 0; d < AHV; d++) a_vec[d] = mv(d, off);
    endtask

    // Counts wrong lanes and wrong lane-valid bits for slice k of A.
    task automatic chk_slice_a(string tag, int k, int off);
        int nd = 0;
        int nl = 0;
        for (int j = 0; j < ADC; j++) begin
            int d = k * ADC + j;
            logic [7:0] e = (d < AHV) ? mv(d, off) : 8'h00;
            if (a_slice[j] !== e) nd++;
            if (a_lv[j] !== (d < AHV)) nl++;
        end
        chk({tag, "_data"}, 32'(nd), 32'd0);
        chk({tag, "_lv"}, 32'(nl), 32'd0);
    endtask

    initial begin
        logic [15:0] rp;
        int exp_idx;
        bit done;

        for (int d = 0; d < BHV; d++) b_vec[d] = 8'(8'hA0 + d);
        fill_a(0);

        // async reset assertion
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_idx", 32'(a_idx), 32'd0);
        chk("rst_last", 32'(a_last), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);

        // full stream, no backpressure
        a_in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        chk("s0_valid", 32'(a_out_valid), 32'd1);
        chk("s0_in_ready", 32'(a_in_ready), 32'd0);
        chk("s0_idx", 32'(a_idx), 32'd0);
        chk("s0_last", 32'(a_last), 32'd0);
        chk_slice_a("s0", 0, 0);
        fill_a(7);
        step();
        chk("s1_idx", 32'(a_idx), 32'd1);
        chk_slice_a("s1", 1, 0);
        a_in_valid = 1'b0;
        step();
        chk("s2_idx", 32'(a_idx), 32'd2);
        chk("s2_last", 32'(a_last), 32'd1);
        chk_slice_a("s2", 2, 0);
        chk("s2_lv_hi", 32'(a_lv[99]), 32'd1);
        chk("s2_lv_lo", 32'(a_lv[100]), 32'd0);
        step();
        chk("end_valid", 32'(a_out_valid), 32'd0);
        chk("end_in_ready", 32'(a_in_ready), 32'd1);
        chk("end_idx", 32'(a_idx), 32'd0);

        // backpressure: ready bits accepted at i=1,4,7
        out_ready = 1'b0;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        rp = 16'b0000_0000_1001_0010;
        exp_idx = 0;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            chk("bp_valid", 32'(a_out_valid), 32'd1);
            chk("bp_idx", 32'(a_idx), 32'(exp_idx));
            chk("bp_lane", 32'(a_slice[5]), 32'(mv(exp_idx * ADC + 5, 7)));
            out_ready = rp[i];
            step();
            if (rp[i]) begin
                if (exp_idx == 2) done = 1'b1;
                else exp_idx++;
            end
        end
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_idle", 32'(a_out_valid), 32'd0);

        // clear mid-stream with concurrent in_valid
        fill_a(3);
        out_ready = 1'b1;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
        chk("cl_pre_idx", 32'(a_idx), 32'd1);
        clear = 1'b1;
        a_in_valid = 1'b1;
        step();
        chk("cl_valid", 32'(a_out_valid), 32'd0);
        chk("cl_idx", 32'(a_idx), 32'd0);
        chk("cl_in_ready", 32'(a_in_ready), 32'd0);
        clear = 1'b0;
        step();
        a_in_valid = 1'b0;
        chk("cl_restart_valid", 32'(a_out_valid), 32'd1);
        chk("cl_restart_idx", 32'(a_idx), 32'd0);
        chk_slice_a("cl_s0", 0, 3);
        step();
        step();
        step();
        chk("cl_drain", 32'(a_in_ready), 32'd1);

        // async reset mid-stream
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
        chk("ar_pre_idx", 32'(a_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(a_out_valid), 32'd0);
        chk("ar_idx", 32'(a_idx), 32'd0);
        #1 rst_n = 1'b1;
        step();
        chk("ar_in_ready", 32'(a_in_ready), 32'd1);
        chk("ar_idle", 32'(a_out_valid), 32'd0);

        // single-slice instance with a held cycle
        out_ready = 1'b0;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        chk("b_valid", 32'(b_out_valid), 32'd1);
        chk("b_last", 32'(b_last), 32'd1);
        chk("b_idx", 32'(b_idx), 32'd0);
        chk("b_lv", 32'(b_lv), 32'hF);
        step();
        chk("b_hold_valid", 32'(b_out_valid), 32'd1);
        chk("b_hold_d3", 32'(b_slice[3]), 32'hA3);
        chk("b_hold_d0", 32'(b_slice[0]), 32'hA0);
        out_ready = 1'b1;
        step();
        chk("b_done_valid", 32'(b_out_valid), 32'd0);
        chk("b_done_ready", 32'(b_in_ready), 32'd1);
        chk("b_done_idx", 32'(b_idx), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_slice_seq.md
ENC_SLICE_SEQ -- requirements
Module: enc_slice_seq

Interface
REQ-001 Parameter FEATURE_COUNT, default 8, SHALL set the bit width of one dimension's bundle vector.
REQ-002 Parameter HV_DIM, default 5000, SHALL set the hypervector dimension count.
REQ-003 Parameter DIMS_PER_CC, default 500, SHALL set the dimensions emitted per slice (1..HV_DIM).
REQ-004 Derived localparam NUM_SLICES SHALL equal ceil(HV_DIM/DIMS_PER_CC); IDX_W SHALL equal max(1,clog2(NUM_SLICES)).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-007 clear  input  1  synchronous abort of the current vector.
REQ-008 in_valid  input  1  producer offers a full vector.
REQ-009 in_ready  output  1  block can accept a vector.
REQ-010 bits_to_bundle_arr  input  [FEATURE_COUNT-1:0] x [HV_DIM-1:0] unpacked  full vector.
REQ-011 out_valid  output  1  out_slice holds a valid slice.
REQ-012 out_ready  input  1  consumer accepts the slice.
REQ-013 out_slice  output  [FEATURE_COUNT-1:0] x [DIMS_PER_CC-1:0] unpacked  current slice.
REQ-014 out_lane_valid  output  DIMS_PER_CC  per-lane flag, 1 where lane maps to a real dimension.
REQ-015 slice_idx  output  IDX_W  index of the current slice.
REQ-016 out_last  output  1  current slice is slice NUM_SLICES-1.

Function
REQ-017 FSM SHALL have states IDLE and STREAM; in_ready SHALL be 1 only in IDLE and low while clear=1.
REQ-018 In IDLE, in_valid&in_ready SHALL capture bits_to_bundle_arr into an internal register, set slice_idx=0, and enter STREAM.
REQ-019 out_valid SHALL be 1 exactly while in STREAM; first slice SHALL be valid the cycle after capture (latency 1).
REQ-020 Lane j of out_slice SHALL equal captured dimension slice_idx*DIMS_PER_CC+j when that index is < HV_DIM, else all-zero.
REQ-021 out_lane_valid[j] SHALL be 1 iff slice_idx*DIMS_PER_CC+j < HV_DIM.
REQ-022 out_slice, out_lane_valid, slice_idx, out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 out_valid&out_ready with out_last=0 SHALL increment slice_idx by 1 next cycle.
REQ-024 out_valid&out_ready with out_last=1 SHALL return to IDLE and reset slice_idx to 0 next cycle; in_ready SHALL be 1 that next cycle (no slice/vector overlap).
REQ-025 in_valid in STREAM SHALL be ignored; input vector changes after capture SHALL not affect out_slice.
REQ-026 clear=1 SHALL take priority over all handshakes: next cycle state=IDLE, slice_idx=0, out_valid=0; a concurrent in_valid SHALL not capture.
REQ-027 When NUM_SLICES=1, out_last SHALL be 1 on the only slice and slice_idx SHALL stay 0.
REQ-028 slice_idx SHALL never exceed NUM_SLICES-1 (no wrap beyond last slice).

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, slice_idx=0, out_valid=0, out_last=0; in_ready SHALL be 1 after deassertion.
REQ-030 Reset mid-STREAM SHALL discard the captured vector; captured-data register need not be reset.
REQ-031 out_slice and out_lane_valid values SHALL be don't-care while out_valid=0.

Verification
REQ-032 HV_DIM=5000, DIMS_PER_CC=500, out_ready=1, dimension d = d mod 256 -> 10 slices on consecutive cycles, slice k lane j = (500k+j) mod 256, out_last only at k=9, in_ready high cycle after.
REQ-033 HV_DIM=1100, DIMS_PER_CC=500 -> 3 slices; slice 2 lanes 0..99 = dims 1000..1099, lanes 100..499 zero, out_lane_valid = 100 ones.
REQ-034 Random out_ready backpressure (50%) -> every slice held stable until accepted, no slice skipped or repeated.
REQ-035 clear asserted during slice 4 with in_valid=1 -> next cycle out_valid=0, slice_idx=0, no capture; following vector streams from slice 0.
REQ-036 rst_n pulsed low asynchronously during slice 3 -> out_valid drops without clock edge; post-reset in_ready=1, slice_idx=0.
REQ-037 HV_DIM=DIMS_PER_CC=500 -> single slice with out_last=1, slice_idx=0, return to IDLE after one handshake.
